// File: rtl/find_max_pkg.sv
// Shared types for the streaming extremum finders: FSM state and per-frame
// compare direction.
package find_max_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef enum logic {
        MODE_MAX = 1'b0,
        MODE_MIN = 1'b1
    } mode_t;

endpackage

// File: rtl/extremum_cmp.sv
// Strict "a beats b" comparator: greater for max mode, less for min mode,
// two's-complement or unsigned selected at elaboration time.
module extremum_cmp
    import find_max_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  mode_t            mode,
    output logic             better
);

    logic w_gt;
    logic w_lt;

    generate
        if (SIGNED != 0) begin : g_signed
            assign w_gt = $signed(a) > $signed(b);
            assign w_lt = $signed(a) < $signed(b);
        end else begin : g_unsigned
            assign w_gt = a > b;
            assign w_lt = a < b;
        end
    endgenerate

    // Strict compare so a tie never displaces the earlier sample.
    assign better = (mode == MODE_MIN) ? w_lt : w_gt;

endmodule

// File: rtl/find_extremum.sv
// Streaming max/min finder: consumes one frame of samples and holds the
// extremum value, its index and the frame length until the consumer takes it.
module find_extremum
    import find_max_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int IDX_W  = 8,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic [IDX_W-1:0] out_index,
    output logic [IDX_W-1:0] out_count,
    output logic             out_ovf
);

    localparam logic [IDX_W-1:0] MAX_COUNT = {IDX_W{1'b1}};

    state_t           r_state;
    state_t           w_next_state;
    mode_t            r_mode;
    logic [WIDTH-1:0] r_value;
    logic [IDX_W-1:0] r_index;
    logic [IDX_W-1:0] r_count;
    logic             r_ovf;
    logic             w_accept;
    logic             w_better;

    assign w_accept = in_valid & in_ready;

    extremum_cmp #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_cmp (
        .a      (in_data),
        .b      (r_value),
        .mode   (r_mode),
        .better (w_better)
    );

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: each output of a combinational process gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = in_last ? HOLD : ACCUM;
            ACCUM:   if (w_accept && in_last) w_next_state = HOLD;
            HOLD:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        if (r_state == HOLD) begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
        end
    end

    // Result registers double as the accumulator; they keep the last result
    // after handoff until the next frame's first sample overwrites them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= MODE_MAX;
            r_value <= '0;
            r_index <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            if (r_state == IDLE) begin
                r_mode  <= mode_t'(mode);
                r_value <= in_data;
                r_index <= '0;
                r_count <= IDX_W'(1);
                r_ovf   <= 1'b0;
            end else if (r_count == MAX_COUNT) begin
                r_ovf <= 1'b1;
            end else begin
                r_count <= r_count + IDX_W'(1);
                if (w_better) begin
                    r_value <= in_data;
                    r_index <= r_count;
                end
            end
        end
    end

    assign out_value = r_value;
    assign out_index = r_index;
    assign out_count = r_count;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_find_extremum.sv
// Directed bench for find_extremum: unsigned, signed and narrow-index
// instances driven by per-scenario tasks with hand-computed expectations.
module tb_find_extremum;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;

    logic       in_valid_u = 1'b0, in_valid_s = 1'b0, in_valid_o = 1'b0;
    logic       in_ready_u, in_ready_s, in_ready_o;
    logic       out_valid_u, out_valid_s, out_valid_o;
    logic [7:0] out_value_u, out_value_s, out_value_o;
    logic [7:0] out_index_u, out_index_s, out_count_u, out_count_s;
    logic [2:0] out_index_o, out_count_o;
    logic       out_ovf_u, out_ovf_s, out_ovf_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    find_extremum #(.WIDTH(8), .IDX_W(8), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid_u),
        .in_ready(in_ready_u), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_u), .out_ready(out_ready), .out_value(out_value_u),
        .out_index(out_index_u), .out_count(out_count_u), .out_ovf(out_ovf_u)
    );

    find_extremum #(.WIDTH(8), .IDX_W(8), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid_s),
        .in_ready(in_ready_s), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_value(out_value_s),
        .out_index(out_index_s), .out_count(out_count_s), .out_ovf(out_ovf_s)
    );

    find_extremum #(.WIDTH(8), .IDX_W(3), .SIGNED(0)) dut_o (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid_o),
        .in_ready(in_ready_o), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_o), .out_ready(out_ready), .out_value(out_value_o),
        .out_index(out_index_o), .out_count(out_count_o), .out_ovf(out_ovf_o)
    );

    function automatic logic ready_of(input int sel);
        case (sel)
            0:       return in_ready_u;
            1:       return in_ready_s;
            default: return in_ready_o;
        endcase
    endfunction

    task automatic set_valid(input int sel, input logic v);
        case (sel)
            0:       in_valid_u = v;
            1:       in_valid_s = v;
            default: in_valid_o = v;
        endcase
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic drive_sample(input int sel, input logic [7:0] d, input logic l, input logic m);
        int waited = 0;
        in_data = d;
        in_last = l;
        mode    = m;
        set_valid(sel, 1'b1);
        while (!ready_of(sel) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout dut=%0d data=%0d in_ready stayed 0", sel, d);
        end
        @(negedge clk);
        set_valid(sel, 1'b0);
        in_last = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({out_valid_u, out_value_u, out_index_u, out_count_u, out_ovf_u, in_ready_u} !== {1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_u got v=%b val=%0d idx=%0d cnt=%0d ovf=%b rdy=%b want 0/0/0/0/0/1",
                     out_valid_u, out_value_u, out_index_u, out_count_u, out_ovf_u, in_ready_u);
        end
        checks++;
        if ({out_valid_s, out_value_s, out_index_s, out_count_s, out_ovf_s, in_ready_s} !== {1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_s got v=%b val=%0d idx=%0d cnt=%0d ovf=%b rdy=%b want 0/0/0/0/0/1",
                     out_valid_s, out_value_s, out_index_s, out_count_s, out_ovf_s, in_ready_s);
        end
        checks++;
        if ({out_valid_o, out_value_o, out_index_o, out_count_o, out_ovf_o, in_ready_o} !== {1'b0, 8'd0, 3'd0, 3'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_o got v=%b val=%0d idx=%0d cnt=%0d ovf=%b rdy=%b want 0/0/0/0/0/1",
                     out_valid_o, out_value_o, out_index_o, out_count_o, out_ovf_o, in_ready_o);
        end
    endtask

    task automatic test_unsigned_max;
        out_ready = 1'b0;
        drive_sample(0, 8'd3, 1'b0, 1'b0);
        drive_sample(0, 8'd9, 1'b0, 1'b0);
        drive_sample(0, 8'd9, 1'b0, 1'b0);
        drive_sample(0, 8'd2, 1'b1, 1'b0);
        checks++;
        if ({out_valid_u, out_value_u, out_index_u, out_count_u, out_ovf_u} !== {1'b1, 8'd9, 8'd1, 8'd4, 1'b0}) begin
            failures++;
            $display("FAIL unsigned_max got v=%b val=%0d idx=%0d cnt=%0d ovf=%b want 1/9/1/4/0",
                     out_valid_u, out_value_u, out_index_u, out_count_u, out_ovf_u);
        end
    endtask

    task automatic test_backpressure;
        in_data    = 8'd55;
        in_last    = 1'b1;
        in_valid_u = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({in_ready_u, out_valid_u, out_value_u, out_index_u, out_count_u} !== {1'b0, 1'b1, 8'd9, 8'd1, 8'd4}) begin
                failures++;
                $display("FAIL backpressure_hold[%0d] got rdy=%b v=%b val=%0d idx=%0d cnt=%0d want 0/1/9/1/4",
                         i, in_ready_u, out_valid_u, out_value_u, out_index_u, out_count_u);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid_u, in_ready_u, out_value_u, out_count_u} !== {1'b0, 1'b1, 8'd9, 8'd4}) begin
            failures++;
            $display("FAIL handoff got v=%b rdy=%b val=%0d cnt=%0d want 0/1/9/4",
                     out_valid_u, in_ready_u, out_value_u, out_count_u);
        end
        @(negedge clk);
        in_valid_u = 1'b0;
        in_last    = 1'b0;
        checks++;
        if ({out_valid_u, out_value_u, out_index_u, out_count_u} !== {1'b1, 8'd55, 8'd0, 8'd1}) begin
            failures++;
            $display("FAIL post_handoff_frame got v=%b val=%0d idx=%0d cnt=%0d want 1/55/0/1",
                     out_valid_u, out_value_u, out_index_u, out_count_u);
        end
    endtask

    task automatic test_signed;
        drive_sample(1, 8'hFB, 1'b0, 1'b0);
        drive_sample(1, 8'hFE, 1'b0, 1'b0);
        drive_sample(1, 8'hF9, 1'b1, 1'b0);
        checks++;
        if ({out_valid_s, out_value_s, out_index_s, out_count_s, out_ovf_s} !== {1'b1, 8'hFE, 8'd1, 8'd3, 1'b0}) begin
            failures++;
            $display("FAIL signed_max got v=%b val=%h idx=%0d cnt=%0d ovf=%b want 1/fe/1/3/0",
                     out_valid_s, out_value_s, out_index_s, out_count_s, out_ovf_s);
        end
        drive_sample(1, 8'hFB, 1'b0, 1'b1);
        drive_sample(1, 8'hFE, 1'b0, 1'b1);
        drive_sample(1, 8'hF9, 1'b1, 1'b1);
        checks++;
        if ({out_valid_s, out_value_s, out_index_s, out_count_s, out_ovf_s} !== {1'b1, 8'hF9, 8'd2, 8'd3, 1'b0}) begin
            failures++;
            $display("FAIL signed_min got v=%b val=%h idx=%0d cnt=%0d ovf=%b want 1/f9/2/3/0",
                     out_valid_s, out_value_s, out_index_s, out_count_s, out_ovf_s);
        end
    endtask

    task automatic test_bubbles_mode;
        drive_sample(0, 8'd4, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            mode = ~mode;
            @(negedge clk);
        end
        checks++;
        if ({out_valid_u, in_ready_u, out_value_u, out_count_u} !== {1'b0, 1'b1, 8'd4, 8'd1}) begin
            failures++;
            $display("FAIL bubble_idle got v=%b rdy=%b val=%0d cnt=%0d want 0/1/4/1",
                     out_valid_u, in_ready_u, out_value_u, out_count_u);
        end
        drive_sample(0, 8'd10, 1'b0, 1'b1);
        drive_sample(0, 8'd1, 1'b1, 1'b1);
        checks++;
        if ({out_valid_u, out_value_u, out_index_u, out_count_u, out_ovf_u} !== {1'b1, 8'd10, 8'd1, 8'd3, 1'b0}) begin
            failures++;
            $display("FAIL bubble_mode got v=%b val=%0d idx=%0d cnt=%0d ovf=%b want 1/10/1/3/0",
                     out_valid_u, out_value_u, out_index_u, out_count_u, out_ovf_u);
        end
        drive_sample(0, 8'd7, 1'b1, 1'b0);
        checks++;
        if ({out_valid_u, out_value_u, out_index_u, out_count_u, out_ovf_u} !== {1'b1, 8'd7, 8'd0, 8'd1, 1'b0}) begin
            failures++;
            $display("FAIL single_sample got v=%b val=%0d idx=%0d cnt=%0d ovf=%b want 1/7/0/1/0",
                     out_valid_u, out_value_u, out_index_u, out_count_u, out_ovf_u);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] samples [9] = '{8'd10, 8'd50, 8'd30, 8'd60, 8'd20, 8'd5, 8'd40, 8'd100, 8'd200};
        for (int i = 0; i < 9; i++)
            drive_sample(2, samples[i], (i == 8), 1'b0);
        checks++;
        if ({out_valid_o, out_value_o, out_index_o, out_count_o, out_ovf_o} !== {1'b1, 8'd60, 3'd3, 3'd7, 1'b1}) begin
            failures++;
            $display("FAIL overflow got v=%b val=%0d idx=%0d cnt=%0d ovf=%b want 1/60/3/7/1",
                     out_valid_o, out_value_o, out_index_o, out_count_o, out_ovf_o);
        end
    endtask

    task automatic test_reset_midframe;
        @(negedge clk);
        drive_sample(0, 8'd200, 1'b0, 1'b0);
        drive_sample(0, 8'd250, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid_u, out_value_u, out_index_u, out_count_u, out_ovf_u, in_ready_u} !== {1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_midframe got v=%b val=%0d idx=%0d cnt=%0d ovf=%b rdy=%b want 0/0/0/0/0/1",
                     out_valid_u, out_value_u, out_index_u, out_count_u, out_ovf_u, in_ready_u);
        end
        checks++;
        if (out_ovf_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_clears_ovf got ovf=%b want 0", out_ovf_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_sample(0, 8'd5, 1'b1, 1'b0);
        checks++;
        if ({out_valid_u, out_value_u, out_index_u, out_count_u, out_ovf_u} !== {1'b1, 8'd5, 8'd0, 8'd1, 1'b0}) begin
            failures++;
            $display("FAIL after_reset_frame got v=%b val=%0d idx=%0d cnt=%0d ovf=%b want 1/5/0/1/0",
                     out_valid_u, out_value_u, out_index_u, out_count_u, out_ovf_u);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_unsigned_max;
        test_backpressure;
        test_signed;
        test_bubbles_mode;
        test_overflow;
        test_reset_midframe;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
